// File: rtl/bp_fifo.sv
// Byte FIFO for a BytePipe valid/ready link with first-word fall-through head output.
// Occupancy comes from pointer difference; one extra pointer bit separates full from empty.
module bp_fifo #(
  parameter int unsigned DEPTH = 8
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_cg,
  input  logic                         i_flush,
  input  logic [7:0]                   i_bp_data,
  input  logic                         i_bp_valid,
  output logic                         o_bp_ready,
  output logic [7:0]                   o_bp_data,
  output logic                         o_bp_valid,
  input  logic                         i_bp_ready,
  output logic [$clog2(DEPTH):0]       o_nEntries,
  output logic                         o_full,
  output logic                         o_empty
);

  localparam int unsigned ADDR_W = $clog2(DEPTH);
  localparam int unsigned PTR_W  = ADDR_W + 1;

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [7:0]        mem_q [DEPTH];
  logic              full_c, empty_c;
  logic              push_c, pop_c;
  logic              mem_we_c;
  logic [ADDR_W-1:0] wr_idx_c, rd_idx_c;

  // Status derived purely from registered pointers, so ready never depends on i_bp_ready
  always_comb begin
    wr_idx_c = wr_ptr_q[ADDR_W-1:0];
    rd_idx_c = rd_ptr_q[ADDR_W-1:0];
    empty_c  = (wr_ptr_q == rd_ptr_q);
    full_c   = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) && (wr_idx_c == rd_idx_c);
  end

  assign o_bp_ready = i_cg && !full_c;
  assign o_bp_valid = i_cg && !empty_c;
  assign o_bp_data  = empty_c ? 8'h00 : mem_q[rd_idx_c];
  assign o_nEntries = PTR_W'(wr_ptr_q - rd_ptr_q);
  assign o_full     = full_c;
  assign o_empty    = empty_c;

  // Next-pointer logic; flush discards everything including a same-cycle push
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    push_c   = i_bp_valid && o_bp_ready;
    pop_c    = o_bp_valid && i_bp_ready;
    mem_we_c = 1'b0;
    if (i_cg) begin
      if (i_flush) begin
        rd_ptr_d = wr_ptr_q;
      end else begin
        if (push_c) begin
          wr_ptr_d = PTR_W'(wr_ptr_q + PTR_W'(1));
          mem_we_c = 1'b1;
        end
        if (pop_c) begin
          rd_ptr_d = PTR_W'(rd_ptr_q + PTR_W'(1));
        end
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage has no reset; contents behind the read pointer are don't-care
  always_ff @(posedge i_clk) begin
    if (mem_we_c) begin
      mem_q[wr_idx_c] <= i_bp_data;
    end
  end

endmodule

// File: tb/tb_bp_fifo.sv
// Scoreboard bench for bp_fifo: directed scenarios followed by a random valid/ready/cg/flush mix.
module tb_bp_fifo;

  localparam int unsigned DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cg = 1'b1;
  logic       flush = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       out_rdy = 1'b0;
  logic       o_bp_ready, o_bp_valid, o_full, o_empty;
  logic [7:0] o_bp_data;
  logic [3:0] o_nEntries;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] sb[$];
  int         cnt_m = 0;

  bp_fifo #(.DEPTH(DEPTH)) dut (
    .i_clk(clk), .i_rst(rst), .i_cg(cg), .i_flush(flush),
    .i_bp_data(in_data), .i_bp_valid(in_valid), .o_bp_ready(o_bp_ready),
    .o_bp_data(o_bp_data), .o_bp_valid(o_bp_valid), .i_bp_ready(out_rdy),
    .o_nEntries(o_nEntries), .o_full(o_full), .o_empty(o_empty)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a byte list plus a count, updated with the inputs seen at each edge
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_m = 0;
      sb.delete();
    end else if (cg) begin
      if (flush) begin
        cnt_m = 0;
        sb.delete();
      end else begin
        bit pu, po;
        pu = in_valid && (cnt_m < DEPTH);
        po = out_rdy && (cnt_m > 0);
        if (pu) sb.push_back(in_data);
        cnt_m = cnt_m + int'(pu) - int'(po);
      end
    end
  end

  // Monitor: compare status each cycle, pop the scoreboard on every expected handshake
  always @(negedge clk) begin
    if (!rst) begin
      check("ready",    32'(o_bp_ready), 32'(cg && cnt_m < DEPTH));
      check("valid",    32'(o_bp_valid), 32'(cg && cnt_m > 0));
      check("nEntries", 32'(o_nEntries), 32'(cnt_m));
      check("full",     32'(o_full),     32'(cnt_m == DEPTH));
      check("empty",    32'(o_empty),    32'(cnt_m == 0));
      check("data",     32'(o_bp_data),  (cnt_m > 0 && sb.size() > 0) ? 32'(sb[0]) : 32'h0);
      if (cg && cnt_m > 0 && out_rdy && sb.size() > 0) void'(sb.pop_front());
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_seq(input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(base + 8'(i));
      cyc(1);
    end
    in_valid = 1'b0;
  endtask

  task automatic drain;
    out_rdy = 1'b1;
    cyc(DEPTH + 2);
    out_rdy = 1'b0;
  endtask

  initial begin
    bit acc;
    cyc(3);
    rst = 1'b0;
    cyc(2);
    check("rst_empty", 32'(o_empty), 32'h1);
    check("rst_valid", 32'(o_bp_valid), 32'h0);
    check("rst_data", 32'(o_bp_data), 32'h0);
    check("rst_ready", 32'(o_bp_ready), 32'h1);
    check("rst_n", 32'(o_nEntries), 32'h0);

    // Single byte fall-through latency
    in_valid = 1'b1; in_data = 8'h81;
    cyc(1);
    in_valid = 1'b0;
    check("ft_valid", 32'(o_bp_valid), 32'h1);
    check("ft_data", 32'(o_bp_data), 32'h81);
    check("ft_n", 32'(o_nEntries), 32'h1);
    drain();

    // Fill to full, hold a ninth byte, then drain
    push_seq(DEPTH, 8'h00);
    in_valid = 1'b1; in_data = 8'hAA;
    cyc(3);
    check("full_flag", 32'(o_full), 32'h1);
    check("full_ready", 32'(o_bp_ready), 32'h0);
    out_rdy = 1'b1;
    cyc(2);
    in_valid = 1'b0;
    cyc(DEPTH + 2);
    check("aa_drained", 32'(o_empty), 32'h1);
    out_rdy = 1'b0;

    // Half full steady streaming across pointer wrap
    push_seq(4, 8'h10);
    in_valid = 1'b1; out_rdy = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_data = 8'(8'h40 + 8'(i));
      cyc(1);
      check("stream_n", 32'(o_nEntries), 32'h4);
    end
    in_valid = 1'b0;
    drain();

    // Flush overrides a simultaneous push
    push_seq(5, 8'h20);
    in_valid = 1'b1; in_data = 8'h55; flush = 1'b1;
    cyc(1);
    in_valid = 1'b0; flush = 1'b0;
    check("flush_empty", 32'(o_empty), 32'h1);
    check("flush_n", 32'(o_nEntries), 32'h0);
    out_rdy = 1'b1;
    cyc(3);
    check("flush_no55", 32'(o_bp_valid), 32'h0);
    out_rdy = 1'b0;

    // Clock gate low blocks all transfers
    push_seq(3, 8'h30);
    in_valid = 1'b1; in_data = 8'h66; out_rdy = 1'b1; cg = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc(1);
      check("cg_n", 32'(o_nEntries), 32'h3);
    end
    cg = 1'b1;
    cyc(3);
    // Asynchronous reset mid-burst
    #1 rst = 1'b1;
    #1;
    check("arst_empty", 32'(o_empty), 32'h1);
    check("arst_n", 32'(o_nEntries), 32'h0);
    #1 rst = 1'b0;
    in_valid = 1'b0; out_rdy = 1'b0;
    cyc(2);

    // Random traffic honouring the upstream hold rule
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      acc = in_valid && o_bp_ready;
      @(posedge clk);
      #1;
      if (acc || !in_valid) begin
        in_valid = ($urandom_range(0, 99) < 60);
        in_data  = 8'($urandom);
      end
      out_rdy = ($urandom_range(0, 99) < 50);
      cg      = ($urandom_range(0, 99) < 92);
      flush   = ($urandom_range(0, 99) < 3);
    end
    in_valid = 1'b0; flush = 1'b0; cg = 1'b1;
    drain();
    check("final_empty", 32'(o_empty), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
